pcie_rx_drain: RTL and testbench
================================

# pcie_rx_drain

Receive-side drain engine for the PCIe transaction block: it sits on the destination end of `pcie_trans` and consumes words from its two destination FIFOs (D0, D1). It arbitrates round-robin between the two FIFOs using their `can_pop` flags, issues the pops, and captures the returned words. It presents the words as a single registered stream tagged with their source, and keeps per-destination word counters readable on request.

## Interface
- `BITNUMBER`, 6, word width (matches `pcie_trans` data width)
- `CNT_WIDTH`, 5, width of each per-destination word counter
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `D0_can_pop`  in  1  D0 FIFO holds at least one word
- `D1_can_pop`  in  1  D1 FIFO holds at least one word
- `data_out0`  in  BITNUMBER  D0 FIFO read data, valid the cycle after `pop_D0`
- `data_out1`  in  BITNUMBER  D1 FIFO read data, valid the cycle after `pop_D1`
- `sink_pause`  in  1  downstream asks to stop new pops
- `cnt_req`  in  1  counter read request
- `cnt_idx`  in  1  counter select: 0 = D0, 1 = D1
- `pop_D0`  out  1  pop strobe to D0 FIFO (combinational)
- `pop_D1`  out  1  pop strobe to D1 FIFO (combinational)
- `data_rx`  out  BITNUMBER  received word (registered)
- `valid_rx`  out  1  `data_rx` valid this cycle
- `src_rx`  out  1  source of `data_rx`: 0 = D0, 1 = D1
- `cnt_data`  out  CNT_WIDTH  counter readout
- `cnt_valid`  out  1  `cnt_data` valid this cycle
- `state`  out  2  debug state: 0 = RESET, 1 = IDLE, 2 = ACTIVE

## Operation
- **Eligibility:** a pop is eligible when `reset` = 0, `state` != RESET, `sink_pause` = 0, and the corresponding `can_pop` = 1.
- **Pop rate:** at most one pop per cycle, and `pop_D0` and `pop_D1` are never high together.
- **Arbitration:**
  - Only one FIFO eligible: pop that FIFO.
  - Both FIFOs eligible: pop the one not granted most recently.
  - Last-grant pointer resets to D1, so D0 wins the first tie.
  - The pointer updates only when a pop is issued.
- **Pipeline:** a 1-bit in-flight flag and a 1-bit in-flight source register record each pop. In the following cycle the block samples the matching `data_outX` into `data_rx` at the clock edge. `valid_rx` and `src_rx` are set alongside.
- **Pause:**
  - `sink_pause` blocks new pops only.
  - An in-flight word is always delivered. The downstream must accept every `valid_rx` word; there is no backpressure on `valid_rx`.
- **Counters:**
  - Two counters, `cnt0` and `cnt1`.
  - The counter for `src_rx` increments on each word loaded into `data_rx`.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- **Counter read:**
  - `cnt_req` = 1 loads `cnt_data` with the selected counter and raises `cnt_valid` for one cycle.
  - If an increment and a read of the same counter happen in the same cycle, the read returns the pre-increment value.
  - Reads do not clear the counters.
- **State:**
  - RESET while `reset` = 1.
  - The cycle after `reset` deasserts, `state` = IDLE.
  - Afterwards `state` = ACTIVE in the cycle following a cycle in which a pop was issued; otherwise IDLE.
  - No pops are issued while `state` = RESET.

## Timing
- **Reset values:** `data_rx` = 0, `valid_rx` = 0, `src_rx` = 0, `cnt_data` = 0, `cnt_valid` = 0, `state` = 0, `cnt0` = `cnt1` = 0, in-flight flag = 0, pointer = D1.
- **Pops during reset:** `pop_D0` and `pop_D1` are 0 while `reset` = 1 and during the first cycle after release.
- **Latency:** pop in cycle N, FIFO data on `data_outX` in cycle N+1, `valid_rx`/`data_rx`/`src_rx` asserted in cycle N+2. Latency is 2 cycles, independent of pause.
- **Throughput:** one word per cycle with back-to-back pops. Alternation under continuous dual eligibility: D0, D1, D0, D1, …
- **`can_pop` drops** in the same cycle as a would-be pop: no pop is issued.
- **`sink_pause` rises** in cycle N: no pop in cycle N. Words popped in cycle N-1 still appear in cycle N+1.
- **Reset mid-operation:** the in-flight word is discarded and `valid_rx` = 0 from the next edge. Counters clear and the pointer returns to D1.
- **`cnt_valid`** is high exactly one cycle per `cnt_req` cycle, with 1-cycle latency.

## Test plan
- **Reset:** hold `reset` high for 3 cycles with both `can_pop` = 1 -> no pops; all outputs 0; `state` = 0; first pop occurs 2 cycles after release and is `pop_D0`.
- **Single source:** D0 only, words 6'h05, 6'h2A, 6'h13 -> three consecutive `pop_D0`; `data_rx` = 05, 2A, 13 with `src_rx` = 0, each 2 cycles after its pop; `cnt0` = 3.
- **Arbitration:** both FIFOs eligible for 6 cycles -> pops D0, D1, D0, D1, D0, D1; `cnt0` = `cnt1` = 3; never both pops high.
- **Pause:** `sink_pause` high for cycles 4–7 during a stream -> no pops in cycles 4–7; word popped in cycle 3 delivered in cycle 5; pops resume in cycle 8 with the pointer unchanged.
- **Saturation/readback:** push 35 words via D1, then `cnt_req` = 1 with `cnt_idx` = 1 -> `cnt_data` = 31, `cnt_valid` pulses one cycle; `cnt_idx` = 0 -> 0.
- **Reset mid-flight:** assert `reset` the cycle after a pop -> no `valid_rx` for that word; counters read 0 after release.

Source files
------------

// File: rtl/pcie_rx_drain.sv
// Receive-side drain engine: round-robin pops from the two destination FIFOs,
// captures the returned words into a registered, source-tagged stream, and
// keeps saturating per-destination word counters readable on request.
module pcie_rx_drain #(
  parameter int BITNUMBER = 6,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 D0_can_pop,
  input  logic                 D1_can_pop,
  input  logic [BITNUMBER-1:0] data_out0,
  input  logic [BITNUMBER-1:0] data_out1,
  input  logic                 sink_pause,
  input  logic                 cnt_req,
  input  logic                 cnt_idx,
  output logic                 pop_D0,
  output logic                 pop_D1,
  output logic [BITNUMBER-1:0] data_rx,
  output logic                 valid_rx,
  output logic                 src_rx,
  output logic [CNT_WIDTH-1:0] cnt_data,
  output logic                 cnt_valid,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic                 last_grant;      // 1 = D1 was granted most recently
  logic                 inflight_p0;     // a pop was issued last cycle
  logic                 inflight_src_p0; // source of that pop
  logic                 eligible;
  logic [CNT_WIDTH-1:0] cnt0;
  logic [CNT_WIDTH-1:0] cnt1;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign state = state_q;

  // Arbitration, pop strobes and next debug state.
  always_comb begin
    pop_D0    = 1'b0;
    pop_D1    = 1'b0;
    state_nxt = ST_IDLE;
    eligible  = !reset && (state_q != ST_RESET) && !sink_pause;
    if (eligible) begin
      if (D0_can_pop && D1_can_pop) begin
        pop_D0 = last_grant;
        pop_D1 = !last_grant;
      end else begin
        pop_D0 = D0_can_pop;
        pop_D1 = D1_can_pop;
      end
    end
    if (reset)
      state_nxt = ST_RESET;
    else if (pop_D0 || pop_D1)
      state_nxt = ST_ACTIVE;
  end

  // Debug state register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= ST_RESET;
    else
      state_q <= state_nxt;
  end

  // Stage p0: record the issued pop and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_p0     <= 1'b0;
      inflight_src_p0 <= 1'b0;
      last_grant      <= 1'b1;
    end else begin
      inflight_p0     <= pop_D0 || pop_D1;
      inflight_src_p0 <= pop_D1;
      if (pop_D0 || pop_D1)
        last_grant <= pop_D1;
    end
  end

  // Stage p1: capture the FIFO read data and count delivered words.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_rx  <= '0;
      valid_rx <= 1'b0;
      src_rx   <= 1'b0;
      cnt0     <= '0;
      cnt1     <= '0;
    end else begin
      valid_rx <= inflight_p0;
      if (inflight_p0) begin
        data_rx <= inflight_src_p0 ? data_out1 : data_out0;
        src_rx  <= inflight_src_p0;
        if (inflight_src_p0)
          cnt1 <= sat_inc(cnt1);
        else
          cnt0 <= sat_inc(cnt0);
      end
    end
  end

  // Counter readout; samples the pre-increment value when both coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= cnt_req;
      if (cnt_req)
        cnt_data <= cnt_idx ? cnt1 : cnt0;
    end
  end

endmodule

// File: tb/tb_pcie_rx_drain.sv
// Bench for pcie_rx_drain: a vector table for reset/arbitration, directed
// multi-cycle sequences, and randomized traffic against a delivery-queue model.
module tb_pcie_rx_drain;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       D0_can_pop = 1'b0;
  logic       D1_can_pop = 1'b0;
  logic [5:0] data_out0 = '0;
  logic [5:0] data_out1 = '0;
  logic       sink_pause = 1'b0;
  logic       cnt_req = 1'b0;
  logic       cnt_idx = 1'b0;
  logic       pop_D0, pop_D1, valid_rx, src_rx, cnt_valid;
  logic [5:0] data_rx;
  logic [4:0] cnt_data;
  logic [1:0] state;

  pcie_rx_drain #(.BITNUMBER(6), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .D0_can_pop(D0_can_pop), .D1_can_pop(D1_can_pop),
    .data_out0(data_out0), .data_out1(data_out1), .sink_pause(sink_pause),
    .cnt_req(cnt_req), .cnt_idx(cnt_idx), .pop_D0(pop_D0), .pop_D1(pop_D1),
    .data_rx(data_rx), .valid_rx(valid_rx), .src_rx(src_rx),
    .cnt_data(cnt_data), .cnt_valid(cnt_valid), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [5:0] word;
    bit         src;
  } deliv_t;

  typedef struct {
    bit r, c0, c1, p;
    bit x0, x1;
    int xs;
  } vec_t;

  int         checks = 0;
  int         errors = 0;

  // Reference model: words scheduled for delivery two cycles after their pop.
  deliv_t     dq[$];
  logic [5:0] fixed_q[$];
  int         cyc = 0;
  bit         prev_reset = 1'b1;
  bit         prev_pop = 1'b0;
  bit         prev_pop_src = 1'b0;
  bit         prev_req = 1'b0;
  bit         m_last = 1'b1;
  int         delivered [2] = '{0, 0};
  logic [5:0] hold_data = '0;
  bit         hold_src = 1'b0;
  int         hold_cnt = 0;
  vec_t       tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, check at the falling edge, advance.
  task automatic tick(input bit r, input bit c0, input bit c1, input bit p,
                      input bit rq, input bit ix,
                      output bit a0, output bit a1, output logic [1:0] ast);
    int         est;
    bit         ev, ecv, elig, e0, e1;
    logic [5:0] w;
    reset      = r;
    D0_can_pop = c0;
    D1_can_pop = c1;
    sink_pause = p;
    cnt_req    = rq;
    cnt_idx    = ix;
    data_out0  = 6'($urandom);
    data_out1  = 6'($urandom);
    if (prev_pop) begin
      w = 6'($urandom);
      if (fixed_q.size() > 0) w = fixed_q.pop_front();
      if (prev_pop_src) data_out1 = w;
      else data_out0 = w;
      dq.push_back('{cyc + 1, w, prev_pop_src});
    end
    if (prev_reset) begin
      dq.delete();
      delivered = '{0, 0};
      hold_data = '0;
      hold_src  = 1'b0;
      hold_cnt  = 0;
      m_last    = 1'b1;
      est       = 0;
    end else begin
      est = prev_pop ? 2 : 1;
    end
    ev = 1'b0;
    if (!prev_reset && dq.size() > 0 && dq[0].due == cyc) begin
      ev        = 1'b1;
      hold_data = dq[0].word;
      hold_src  = dq[0].src;
      delivered[dq[0].src]++;
      void'(dq.pop_front());
    end
    ecv  = prev_req;
    elig = !r && (est != 0) && !p;
    e0   = elig && c0 && (!c1 || m_last);
    e1   = elig && c1 && (!c0 || !m_last);
    #4;
    a0  = pop_D0;
    a1  = pop_D1;
    ast = state;
    chk("pop_D0", pop_D0, e0);
    chk("pop_D1", pop_D1, e1);
    chk("state", state, est);
    chk("valid_rx", valid_rx, ev);
    chk("data_rx", data_rx, hold_data);
    chk("src_rx", src_rx, hold_src);
    chk("cnt_valid", cnt_valid, ecv);
    chk("cnt_data", cnt_data, hold_cnt);
    if (!r && rq) hold_cnt = (delivered[ix] > 31) ? 31 : delivered[ix];
    prev_req     = !r && rq;
    prev_reset   = r;
    prev_pop     = e0 || e1;
    prev_pop_src = e1;
    if (e0 || e1) m_last = e1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic t(input bit r, input bit c0, input bit c1, input bit p,
                   input bit rq, input bit ix);
    bit a0, a1;
    logic [1:0] ast;
    tick(r, c0, c1, p, rq, ix, a0, a1, ast);
  endtask

  task automatic do_reset();
    t(1, 1, 1, 0, 0, 0);
    t(1, 1, 1, 0, 0, 0);
    t(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit a0, a1;
    logic [1:0] ast;

    tbl[0]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 1, 0, 1};
    tbl[5]  = '{0, 1, 1, 0, 0, 1, 2};
    tbl[6]  = '{0, 1, 1, 0, 1, 0, 2};
    tbl[7]  = '{0, 1, 1, 0, 0, 1, 2};
    tbl[8]  = '{0, 1, 1, 0, 1, 0, 2};
    tbl[9]  = '{0, 1, 1, 0, 0, 1, 2};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 2};
    tbl[11] = '{0, 1, 0, 0, 1, 0, 1};
    tbl[12] = '{0, 1, 1, 1, 0, 0, 2};
    tbl[13] = '{0, 1, 1, 0, 0, 1, 1};
    tbl[14] = '{0, 1, 0, 0, 1, 0, 2};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 2};

    @(posedge clk);
    #1;

    // Reset hold, release, alternation, idle, pause and single-source vectors.
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].r, tbl[i].c0, tbl[i].c1, tbl[i].p, 0, 0, a0, a1, ast);
      chk("tbl_pop_D0", a0, tbl[i].x0);
      chk("tbl_pop_D1", a1, tbl[i].x1);
      chk("tbl_state", ast, tbl[i].xs);
    end

    // Single source D0 with fixed words, then counter readback.
    do_reset();
    fixed_q = '{6'h05, 6'h2A, 6'h13};
    t(0, 1, 0, 0, 0, 0);
    t(0, 1, 0, 0, 0, 0);
    chk("single_data0", data_rx, 6'h05);
    chk("single_src0", src_rx, 1'b0);
    chk("single_valid0", valid_rx, 1'b1);
    t(0, 1, 0, 0, 0, 0);
    chk("single_data1", data_rx, 6'h2A);
    t(0, 0, 0, 0, 0, 0);
    chk("single_data2", data_rx, 6'h13);
    t(0, 0, 0, 0, 0, 0);
    t(0, 0, 0, 0, 1, 0);
    chk("single_cnt0", cnt_data, 5'd3);
    chk("single_cnt_valid", cnt_valid, 1'b1);
    t(0, 0, 0, 0, 0, 0);
    chk("single_cnt_valid_drop", cnt_valid, 1'b0);

    // Pause window in the middle of a dual-source stream.
    do_reset();
    repeat (3) t(0, 1, 1, 0, 0, 0);
    repeat (4) t(0, 1, 1, 1, 0, 0);
    repeat (3) t(0, 1, 1, 0, 0, 0);
    repeat (2) t(0, 0, 0, 0, 0, 0);

    // Saturation of the D1 counter and readback of both counters.
    do_reset();
    repeat (35) t(0, 0, 1, 0, 0, 0);
    repeat (2) t(0, 0, 0, 0, 0, 0);
    t(0, 0, 0, 0, 1, 1);
    chk("sat_cnt1", cnt_data, 5'd31);
    chk("sat_cnt_valid", cnt_valid, 1'b1);
    t(0, 0, 0, 0, 1, 0);
    chk("sat_cnt0", cnt_data, 5'd0);

    // Reset the cycle after a pop: the word is never delivered.
    do_reset();
    t(0, 1, 0, 0, 0, 0);
    t(1, 0, 0, 0, 0, 0);
    chk("midrst_valid_a", valid_rx, 1'b0);
    t(0, 0, 0, 0, 0, 0);
    chk("midrst_valid_b", valid_rx, 1'b0);
    t(0, 0, 0, 0, 1, 0);
    chk("midrst_cnt0", cnt_data, 5'd0);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      t(($urandom % 60) == 0, ($urandom % 3) != 0, ($urandom % 3) != 0,
        ($urandom % 5) == 0, ($urandom % 4) == 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
